// File: rtl/key_pkg.sv
// Shared types and helpers for the key_event_ctrl push-button front end.
// Optional auto-repeat is compiled in with `define KEY_REPEAT_EN.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        LONG,
        REL_DB
    } key_state_t;

    localparam int KEY_POL_HIGH = 1;
    localparam int KEY_POL_LOW  = 0;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-flop synchroniser, debounce/long-press FSM and counters.
// Auto-repeat logic is present only when KEY_REPEAT_EN is defined.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic tick,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int DB_W   = cnt_w(DEBOUNCE_TICKS);
    localparam int HOLD_W = cnt_w(LONG_TICKS);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

    logic              key_p0;
    logic              key_p1;
    key_state_t        state;
    logic              was_long;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            key_p0      <= 1'b0;
            key_p1      <= 1'b0;
            state       <= IDLE;
            was_long    <= 1'b0;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            // Synchroniser stage boundary: key_p1 is the only copy the FSM uses.
            key_p0      <= key_raw;
            key_p1      <= key_p0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_p1) begin
                        state  <= PRESS_DB;
                        db_cnt <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!key_p1) begin
                        state <= IDLE;
                    end else if (tick) begin
                        db_cnt <= db_cnt + 1'b1;
                        if (db_cnt == DB_LAST) begin
                            state     <= HELD;
                            key_level <= 1'b1;
                            key_press <= 1'b1;
                            hold_cnt  <= '0;
                        end
                    end
                end
                HELD: begin
                    // A release edge wins over a coincident hold tick.
                    if (!key_p1) begin
                        state    <= REL_DB;
                        was_long <= 1'b0;
                        db_cnt   <= '0;
                    end else if (tick) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= LONG;
                            key_long <= 1'b1;
                        end
                    end
                end
                LONG: begin
                    if (!key_p1) begin
                        state    <= REL_DB;
                        was_long <= 1'b1;
                        db_cnt   <= '0;
                    end
                end
                REL_DB: begin
                    if (key_p1) begin
                        state <= was_long ? LONG : HELD;
                    end else if (tick) begin
                        db_cnt <= db_cnt + 1'b1;
                        if (db_cnt == DB_LAST) begin
                            state       <= IDLE;
                            key_level   <= 1'b0;
                            key_release <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RP_W = cnt_w(REPEAT_TICKS);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_TICKS - 1);

    logic [RP_W-1:0] rep_cnt;

    // rep_cnt is untouched in REL_DB so a bounce back to LONG keeps the phase.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            rep_cnt    <= '0;
            key_repeat <= 1'b0;
        end else begin
            key_repeat <= 1'b0;
            if (state == HELD && key_p1 && tick && hold_cnt == HOLD_LAST) begin
                rep_cnt <= '0;
            end else if (state == LONG && key_p1 && tick) begin
                if (rep_cnt == RP_LAST) begin
                    rep_cnt    <= '0;
                    key_repeat <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_event_ctrl.sv
// N-key front end: shared debounce tick plus one key_channel per key pin.
// Define KEY_REPEAT_EN to enable auto-repeat pulses on key_repeat.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int N_KEYS          = 2,
    parameter int KEY_ACTIVE_HIGH = 1,
    parameter int TICK_CYCLES     = 50000,
    parameter int DEBOUNCE_TICKS  = 20,
    parameter int LONG_TICKS      = 1000,
    parameter int REPEAT_TICKS    = 200
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int TICK_W = cnt_w(TICK_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [N_KEYS-1:0] key_norm;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // A plain inverter ahead of the synchroniser keeps the CDC path glitch-free.
    if (KEY_ACTIVE_HIGH == KEY_POL_HIGH) begin : g_pol_high
        assign key_norm = key_in;
    end else begin : g_pol_low
        assign key_norm = ~key_in;
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS)
        ) u_channel (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .tick        (tick),
            .key_raw     (key_norm[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i]),
            .key_repeat  (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl with an event-level reference model.
// Honours KEY_REPEAT_EN the same way as the design.
`timescale 1ns/1ps
module tb_key_event_ctrl;

    localparam int NK  = 2;
    localparam int TC  = 4;
    localparam int DEB = 3;
    localparam int LT  = 10;
    localparam int RT  = 2;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;
    localparam int EV_REPEAT  = 3;

    typedef struct {
        int cyc;
        int key;
        int kind;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_in = '0;
    logic [NK-1:0] key_in_n;
    logic [NK-1:0] level, press, rel, lng, rpt;
    logic [NK-1:0] level_n, press_n, rel_n, lng_n, rpt_n;

    assign key_in_n = ~key_in;

    always #5 clk = ~clk;

    key_event_ctrl #(
        .N_KEYS(NK), .KEY_ACTIVE_HIGH(1), .TICK_CYCLES(TC),
        .DEBOUNCE_TICKS(DEB), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
    ) dut (
        .sys_clk(clk), .sys_rst(rst_n), .key_in(key_in),
        .key_level(level), .key_press(press), .key_release(rel),
        .key_long(lng), .key_repeat(rpt)
    );

    key_event_ctrl #(
        .N_KEYS(NK), .KEY_ACTIVE_HIGH(0), .TICK_CYCLES(TC),
        .DEBOUNCE_TICKS(DEB), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
    ) dut_n (
        .sys_clk(clk), .sys_rst(rst_n), .key_in(key_in_n),
        .key_level(level_n), .key_press(press_n), .key_release(rel_n),
        .key_long(lng_n), .key_repeat(rpt_n)
    );

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;

    // Reference model: accepted level per key, length of the current run where
    // the synchronised pin disagrees with it, and ticks counted in that run.
    bit  m_lvl[NK];
    int  m_run[NK];
    int  m_dc[NK];
    int  m_hold[NK];
    int  m_rep[NK];
    bit  m_long[NK];
    bit  m_h1[NK];
    bit  m_h2[NK];
    bit  m_prev[NK];
    int  m_tick_n = 0;
    bit  m_t;
    bit  m_s;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_tick_n = 0;
            for (int k = 0; k < NK; k++) begin
                m_lvl[k] = 0; m_run[k] = 0; m_dc[k] = 0; m_hold[k] = 0;
                m_rep[k] = 0; m_long[k] = 0; m_h1[k] = 0; m_h2[k] = 0; m_prev[k] = 0;
            end
        end else begin
            m_t = ((m_tick_n % TC) == TC - 1);
            m_tick_n++;
            for (int k = 0; k < NK; k++) begin
                m_s     = m_h2[k];
                m_h2[k] = m_h1[k];
                m_h1[k] = key_in[k];
                // Hold time accrues only on ticks where the key stayed pressed.
                if (m_lvl[k] && m_s && m_prev[k] && m_t) begin
                    if (!m_long[k]) begin
                        m_hold[k]++;
                        if (m_hold[k] == LT) begin
                            m_long[k] = 1;
                            m_rep[k]  = 0;
                            exp_q.push_back('{cyc, k, EV_LONG});
                        end
                    end else begin
`ifdef KEY_REPEAT_EN
                        m_rep[k]++;
                        if (m_rep[k] == RT) begin
                            m_rep[k] = 0;
                            exp_q.push_back('{cyc, k, EV_REPEAT});
                        end
`endif
                    end
                end
                if (m_s != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_t && m_run[k] >= 2) m_dc[k]++;
                    if (m_dc[k] == DEB) begin
                        m_lvl[k] = m_s;
                        m_run[k] = 0;
                        m_dc[k]  = 0;
                        if (m_s) begin
                            m_hold[k] = 0;
                            m_long[k] = 0;
                            exp_q.push_back('{cyc, k, EV_PRESS});
                        end else begin
                            exp_q.push_back('{cyc, k, EV_RELEASE});
                        end
                    end
                end else begin
                    m_run[k] = 0;
                    m_dc[k]  = 0;
                end
                m_prev[k] = m_s;
            end
        end
    end

    // Monitor: gathers this cycle's expected pulses and compares against the DUT.
    logic [NK-1:0] e_press, e_rel, e_lng, e_rpt, e_lvl;
    ev_t           ev;
    int            ob_press[NK], ob_rel[NK], ob_lng[NK], ob_rpt[NK];
    bit            both_seen = 0;

    initial begin
        for (int k = 0; k < NK; k++) begin
            ob_press[k] = 0; ob_rel[k] = 0; ob_lng[k] = 0; ob_rpt[k] = 0;
        end
    end

    always @(negedge clk) begin
        e_press = '0; e_rel = '0; e_lng = '0; e_rpt = '0;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            ev = exp_q.pop_front();
            if (ev.cyc < cyc) begin
                n_checks++; n_errors++;
                $display("FAIL missed_event kind=%0d key=%0d cyc=%0d now=%0d", ev.kind, ev.key, ev.cyc, cyc);
            end else begin
                case (ev.kind)
                    EV_PRESS:   e_press[ev.key] = 1'b1;
                    EV_RELEASE: e_rel[ev.key]   = 1'b1;
                    EV_LONG:    e_lng[ev.key]   = 1'b1;
                    default:    e_rpt[ev.key]   = 1'b1;
                endcase
            end
        end
        for (int k = 0; k < NK; k++) begin
            e_lvl[k] = m_lvl[k];
            ob_press[k] += int'(press[k]);
            ob_rel[k]   += int'(rel[k]);
            ob_lng[k]   += int'(lng[k]);
            ob_rpt[k]   += int'(rpt[k]);
        end
        if (press == 2'b11) both_seen = 1;
        if (press !== '0 || e_press !== '0) begin
            n_checks++;
            if (press !== e_press) begin
                n_errors++;
                $display("FAIL press cyc=%0d got=%b want=%b", cyc, press, e_press);
            end
        end
        if (rel !== '0 || e_rel !== '0) begin
            n_checks++;
            if (rel !== e_rel) begin
                n_errors++;
                $display("FAIL release cyc=%0d got=%b want=%b", cyc, rel, e_rel);
            end
        end
        if (lng !== '0 || e_lng !== '0) begin
            n_checks++;
            if (lng !== e_lng) begin
                n_errors++;
                $display("FAIL long cyc=%0d got=%b want=%b", cyc, lng, e_lng);
            end
        end
        if (rpt !== '0 || e_rpt !== '0) begin
            n_checks++;
            if (rpt !== e_rpt) begin
                n_errors++;
                $display("FAIL repeat cyc=%0d got=%b want=%b", cyc, rpt, e_rpt);
            end
        end
        n_checks++;
        if (level !== e_lvl) begin
            n_errors++;
            $display("FAIL level cyc=%0d got=%b want=%b", cyc, level, e_lvl);
        end
        if ({level, press, rel, lng, rpt} !== '0 ||
            {level_n, press_n, rel_n, lng_n, rpt_n} !== '0) begin
            n_checks++;
            if ({level_n, press_n, rel_n, lng_n, rpt_n} !== {level, press, rel, lng, rpt}) begin
                n_errors++;
                $display("FAIL active_low_match cyc=%0d got=%b want=%b", cyc,
                         {level_n, press_n, rel_n, lng_n, rpt_n}, {level, press, rel, lng, rpt});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    int base_p, base_r, base_l, base_rp, base_p1, base_r1, base_l1;
    int rem[NK];

    initial begin
        rst_n  = 1'b0;
        key_in = '0;
        step(3);
        check_eq("reset_outputs", int'({level, press, rel, lng, rpt}), 0);
        rst_n = 1'b1;
        step(5);

        // Scenario 1: clean long hold on key 0, then release.
        base_p = ob_press[0]; base_r = ob_rel[0]; base_l = ob_lng[0];
        key_in[0] = 1'b1;
        step(100);
        check_eq("s1_level", int'(level[0]), 1);
        key_in[0] = 1'b0;
        step(40);
        check_eq("s1_press_count", ob_press[0] - base_p, 1);
        check_eq("s1_long_count", ob_lng[0] - base_l, 1);
        check_eq("s1_release_count", ob_rel[0] - base_r, 1);

        // Scenario 2: key 1 chatter shorter than the debounce window.
        base_p1 = ob_press[1]; base_r1 = ob_rel[1]; base_l1 = ob_lng[1];
        for (int i = 0; i < 12; i++) begin
            key_in[1] = ~key_in[1];
            step(5);
        end
        key_in[1] = 1'b0;
        step(40);
        check_eq("s2_press_count", ob_press[1] - base_p1, 0);
        check_eq("s2_release_count", ob_rel[1] - base_r1, 0);
        check_eq("s2_level", int'(level[1]), 0);

        // Scenario 3: short press with a bouncy release.
        base_p = ob_press[0]; base_r = ob_rel[0]; base_l = ob_lng[0];
        key_in[0] = 1'b1;
        step(20);
        for (int i = 0; i < 2; i++) begin
            key_in[0] = 1'b0; step(3);
            key_in[0] = 1'b1; step(3);
        end
        key_in[0] = 1'b0;
        step(40);
        check_eq("s3_press_count", ob_press[0] - base_p, 1);
        check_eq("s3_release_count", ob_rel[0] - base_r, 1);
        check_eq("s3_long_count", ob_lng[0] - base_l, 0);

        // Scenario 4: both keys pressed together.
        key_in = 2'b11;
        step(30);
        key_in = 2'b00;
        step(40);
        check_eq("s4_both_press", int'(both_seen), 1);

        // Scenario 5: long hold for auto-repeat.
        base_rp = ob_rpt[0];
        key_in[0] = 1'b1;
        step(120);
        key_in[0] = 1'b0;
        step(40);
`ifdef KEY_REPEAT_EN
        check_eq("s5_repeat_count", ob_rpt[0] - base_rp, 8);
`else
        check_eq("s5_repeat_count", ob_rpt[0] - base_rp, 0);
`endif

        // Scenario 6: reset while key 0 is in the long-press state.
        key_in[0] = 1'b1;
        step(70);
        base_p = ob_press[0]; base_r = ob_rel[0];
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_eq("s6_reset_outputs", int'({level, press, rel, lng, rpt}), 0);
        step(30);
        check_eq("s6_fresh_press", ob_press[0] - base_p, 1);
        check_eq("s6_no_release", ob_rel[0] - base_r, 0);
        key_in[0] = 1'b0;
        step(40);

        // Random phase: random hold lengths per key, occasional reset.
        for (int k = 0; k < NK; k++) rem[k] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (rem[k] == 0) begin
                    key_in[k] = 1'($urandom_range(0, 1));
                    rem[k]    = int'($urandom_range(1, 40));
                end
                rem[k]--;
            end
            rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        rst_n  = 1'b1;
        key_in = '0;
        step(40);
        check_eq("final_level", int'(level), 0);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
